// File: rtl/scrambler_64b66b_tx_pkg.sv
// Shared constants and types for the 64b/66b transmit scrambler.
// Polynomial x^58 + x^39 + 1 applied to the 64-bit block payload.
package pcs_scr_pkg;

  localparam int LFSR_WIDTH = 58;
  localparam int TAP        = 39;
  localparam int DATA_WIDTH = 64;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [LFSR_WIDTH-1:0] SCR_SEED_DEFAULT =
    58'h3FF_FFFF_FFFF_FFFF;

  typedef logic [LFSR_WIDTH-1:0] scr_state_t;

  typedef struct packed {
    logic [1:0]            sync;
    logic [DATA_WIDTH-1:0] data;
  } blk66_t;

endpackage

// File: rtl/scrambler_64b66b_tx_if.sv
// Valid/ready stream bundle around the scrambler.
// master = upstream/downstream driver side, slave = scrambler side.
interface scrambler_64b66b_tx_if;
  import pcs_scr_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_sync;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            out_sync;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_sync, in_data, out_ready,
    input  in_ready, out_valid, out_sync, out_data
  );

  modport slave (
    input  in_valid, in_sync, in_data, out_ready,
    output in_ready, out_valid, out_sync, out_data
  );

endinterface

// File: rtl/scrambler_64b66b_tx_scr58_comb.sv
// Combinational 64-bit parallel step of the x^58 + x^39 + 1 scrambler.
// state[k] holds the previous block's scrambled bit 6+k.
module scr58_comb
  import pcs_scr_pkg::*;
(
  input  scr_state_t            i_state,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output scr_state_t            o_next_state
);

  always_comb begin
    logic [DATA_WIDTH-1:0] v_s;
    v_s = '0;
    // Low bits draw both taps from the prior block.
    for (int i = 0; i < TAP; i++)
      v_s[i] = i_data[i]
             ^ i_state[i+LFSR_WIDTH-TAP]
             ^ i_state[i];
    for (int i = TAP; i < LFSR_WIDTH; i++)
      v_s[i] = i_data[i] ^ v_s[i-TAP] ^ i_state[i];
    for (int i = LFSR_WIDTH; i < DATA_WIDTH; i++)
      v_s[i] = i_data[i] ^ v_s[i-TAP] ^ v_s[i-LFSR_WIDTH];
    o_data       = v_s;
    o_next_state = v_s[DATA_WIDTH-1:DATA_WIDTH-LFSR_WIDTH];
  end

endmodule

// File: rtl/scrambler_64b66b_tx.sv
// 64b/66b TX scrambler: one registered stage, valid/ready, sync bypass.
// Optional SCRAMBLER_SEED_LOAD_EN adds a runtime seed_load/seed_val port pair.
module scrambler_64b66b_tx #(
  parameter int          DATA_WIDTH = 64,
  parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic                  CLK,
  input  logic                  rst,
  scrambler_64b66b_tx_if.slave  bus,
`ifdef SCRAMBLER_SEED_LOAD_EN
  input  logic                  seed_load,
  input  logic [57:0]           seed_val,
`endif
  output logic [31:0]           blk_cnt
);
  import pcs_scr_pkg::*;

  scr_state_t            r_state;
  scr_state_t            w_next_state;
  blk66_t                r_out_blk;
  logic                  r_out_valid;
  logic [31:0]           r_blk_cnt;
  logic [DATA_WIDTH-1:0] w_scr_data;
  logic                  w_in_ready;
  logic                  w_accept;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  scr58_comb u_scr (
    .i_state      (r_state),
    .i_data       (bus.in_data),
    .o_data       (w_scr_data),
    .o_next_state (w_next_state)
  );

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state     <= SEED;
      r_out_blk   <= '0;
      r_out_valid <= 1'b0;
      r_blk_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_out_blk.data <= w_scr_data;
        r_out_blk.sync <= bus.in_sync;
        r_out_valid    <= 1'b1;
        r_state        <= w_next_state;
        r_blk_cnt      <= r_blk_cnt + 32'd1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
`ifdef SCRAMBLER_SEED_LOAD_EN
      // Seed load wins over the same-cycle beat's state update.
      if (seed_load)
        r_state <= seed_val;
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sync  = r_out_blk.sync;
  assign bus.out_data  = r_out_blk.data;
  assign blk_cnt       = r_blk_cnt;

endmodule

// File: tb/tb_scrambler_64b66b_tx.sv
// Directed bench for scrambler_64b66b_tx with a bit-serial reference.
// Seed-load scenario runs only when SCRAMBLER_SEED_LOAD_EN is defined.
module tb_scrambler_64b66b_tx;
  import pcs_scr_pkg::*;

  localparam logic [63:0] ZERO_VEC = 64'h03FF_FF80_0000_0000;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] blk_cnt;
`ifdef SCRAMBLER_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [57:0] seed_val  = '0;
`endif

  scrambler_64b66b_tx_if bus();

  scrambler_64b66b_tx dut (
    .CLK       (CLK),
    .rst       (rst),
    .bus       (bus),
`ifdef SCRAMBLER_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed_val  (seed_val),
`endif
    .blk_cnt   (blk_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [57:0] m_h;
  logic [57:0] d_h;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Serial scrambler: h[0] is the newest transmitted scrambled bit.
  task automatic ser_scr(input logic [63:0] d, output logic [63:0] s);
    for (int i = 0; i < 64; i++) begin
      s[i] = d[i] ^ m_h[38] ^ m_h[57];
      m_h  = {m_h[56:0], s[i]};
    end
  endtask

  task automatic ser_descr(input logic [63:0] s, output logic [63:0] d);
    for (int i = 0; i < 64; i++) begin
      d[i] = s[i] ^ d_h[38] ^ d_h[57];
      d_h  = {d_h[56:0], s[i]};
    end
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sync   = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b1;
    m_h = '1;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sync   = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", bus.out_data);
    end
    n_cmp++;
    if (bus.out_sync !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_sync: got %b want 00", bus.out_sync);
    end
    n_cmp++;
    if (blk_cnt !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %h want 0", blk_cnt);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    end
    rst = 1'b1;
    m_h = '1;
  endtask

  task automatic test_first_beat();
    do_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    bus.in_sync   = SYNC_DATA;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL first_valid: got %b want 1", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data !== ZERO_VEC) begin
      n_bad++;
      $display("FAIL first_data: got %h want %h",
               bus.out_data, ZERO_VEC);
    end
    n_cmp++;
    if (bus.out_sync !== SYNC_DATA) begin
      n_bad++;
      $display("FAIL first_sync: got %b want 01", bus.out_sync);
    end
    n_cmp++;
    if (blk_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL first_cnt: got %0d want 1", blk_cnt);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL first_drain: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    do_reset();
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'h0123_4567_89AB_CDEF;
    bus.in_sync   = SYNC_CTRL;
    bus.out_ready = 1'b0;
    ser_scr(64'h0123_4567_89AB_CDEF, exp_a);
    step();
    bus.in_data = 64'hFEDC_BA98_7654_3210;
    bus.in_sync = SYNC_DATA;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_ready[%0d]: got %b want 0", k, bus.in_ready);
      end
      n_cmp++;
      if (bus.out_data !== exp_a || bus.out_sync !== SYNC_CTRL) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got %b/%h want 10/%h",
                 k, bus.out_sync, bus.out_data, exp_a);
      end
      n_cmp++;
      if (blk_cnt !== 32'd1) begin
        n_bad++;
        $display("FAIL bp_cnt[%0d]: got %0d want 1", k, blk_cnt);
      end
      step();
    end
    bus.out_ready = 1'b1;
    ser_scr(64'hFEDC_BA98_7654_3210, exp_b);
    step();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b ||
        bus.out_sync !== SYNC_DATA) begin
      n_bad++;
      $display("FAIL bp_resume: got %b/%b/%h want 1/01/%h",
               bus.out_valid, bus.out_sync, bus.out_data, exp_b);
    end
    n_cmp++;
    if (blk_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL bp_resume_cnt: got %0d want 2", blk_cnt);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    logic [63:0] e;
    logic [1:0]  sy;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      d  = 64'hA5A5_0000_0000_5A5A ^ (64'h0101_0101_0101_0101 * k);
      sy = k[0] ? SYNC_CTRL : SYNC_DATA;
      bus.in_data = d;
      bus.in_sync = sy;
      ser_scr(d, e);
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== e ||
          bus.out_sync !== sy) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got %b/%b/%h want 1/%b/%h",
                 k, bus.out_valid, bus.out_sync, bus.out_data, sy, e);
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (blk_cnt !== 32'd10) begin
      n_bad++;
      $display("FAIL b2b_cnt: got %0d want 10", blk_cnt);
    end
    step();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hDEAD_BEEF_CAFE_F00D;
    bus.in_sync   = SYNC_DATA;
    step();
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (blk_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_cnt: got %0d want 0", blk_cnt);
    end
    bus.in_valid = 1'b0;
    step();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    step();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== ZERO_VEC || blk_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL mid_restart: got %h/%0d want %h/1",
               bus.out_data, blk_cnt, ZERO_VEC);
    end
    step();
  endtask

  task automatic test_round_trip();
    logic [65:0] q[$];
    logic [65:0] ex;
    logic [63:0] dd;
    int sent = 0;
    int rcv  = 0;
    int cyc  = 0;
    logic acc;
    logic cons;
    do_reset();
    d_h = '0;
    while (rcv < 1000 && cyc < 20000) begin
      if (!bus.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = {$urandom, $urandom};
        bus.in_sync  = 2'($urandom_range(0, 3));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc  = bus.in_valid && bus.in_ready;
      cons = bus.out_valid && bus.out_ready;
      if (cons) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rt_dup: beat %0d with empty queue", rcv);
        end else begin
          ex = q.pop_front();
          if (bus.out_sync !== ex[65:64]) begin
            n_bad++;
            $display("FAIL rt_sync[%0d]: got %b want %b",
                     rcv, bus.out_sync, ex[65:64]);
          end
          ser_descr(bus.out_data, dd);
          if (rcv > 0) begin
            n_cmp++;
            if (dd !== ex[63:0]) begin
              n_bad++;
              $display("FAIL rt_data[%0d]: got %h want %h",
                       rcv, dd, ex[63:0]);
            end
          end
        end
        rcv++;
      end
      if (acc) begin
        q.push_back({bus.in_sync, bus.in_data});
        sent++;
      end
      @(posedge CLK);
      #1;
      cyc++;
      if (acc) bus.in_valid = 1'b0;
    end
    n_cmp++;
    if (rcv != 1000 || q.size() != 0) begin
      n_bad++;
      $display("FAIL rt_count: got %0d rcv %0d left want 1000/0",
               rcv, q.size());
    end
    n_cmp++;
    if (blk_cnt !== 32'd1000) begin
      n_bad++;
      $display("FAIL rt_blk_cnt: got %0d want 1000", blk_cnt);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.r_blk_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_blk_cnt;
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (blk_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL wrap_cnt: got %h want 0", blk_cnt);
    end
    step();
  endtask

`ifdef SCRAMBLER_SEED_LOAD_EN
  task automatic test_seed_load();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    seed_load     = 1'b1;
    seed_val      = '0;
    step();
    seed_load = 1'b0;
    n_cmp++;
    if (bus.out_data !== ZERO_VEC) begin
      n_bad++;
      $display("FAIL seed_old: got %h want %h", bus.out_data, ZERO_VEC);
    end
    step();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_data !== 64'h0 || blk_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL seed_zero: got %h/%0d want 0/2",
               bus.out_data, blk_cnt);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_first_beat();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_round_trip();
    test_wrap();
`ifdef SCRAMBLER_SEED_LOAD_EN
    test_seed_load();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
